// File: rtl/sample_reader.sv
// sample_reader: streams nwords buffer samples through a 2-entry skid FIFO.
// Define SAMPLE_READER_CHECKSUM_EN to append a modulo-2^DATA_W checksum word.
module sample_reader #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] nwords,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, CSUM, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   nwords_q;
    logic [ADDR_W:0]     issue_q;
    logic [ADDR_W:0]     xfer_q;
    logic [ADDR_W:0]     last_idx;
    logic [ADDR_W-1:0]   last_addr_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;
    logic                done_q, done_d;
    logic                accept;
    logic                fifo_nempty;
    logic                sample_xfer;
    logic                last_sample;
    logic [2:0]          level;
`ifdef SAMPLE_READER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
`endif

    // Credit check counts the pop happening this cycle so a full-rate stream has no bubbles.
    always_comb begin
        accept      = (state_q == IDLE) && start;
        last_idx    = {1'b0, nwords_q} - (ADDR_W+1)'(1);
        fifo_nempty = (count_q != 2'd0);
        sample_xfer = fifo_nempty && m_ready;
        last_sample = fifo_nempty && (xfer_q == last_idx);
        level       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, sample_xfer};
        rd_en       = (state_q == READ) && (issue_q < {1'b0, nwords_q}) && (level < 3'd2);
        rd_addr     = rd_en ? issue_q[ADDR_W-1:0] : last_addr_q;
        m_valid     = fifo_nempty;
        m_data      = fifo_nempty ? fifo_q[rd_ptr_q] : '0;
`ifdef SAMPLE_READER_CHECKSUM_EN
        m_last      = (state_q == CSUM);
        if (state_q == CSUM) begin
            m_valid = 1'b1;
            m_data  = csum_q;
        end
`else
        m_last      = last_sample;
`endif
        done        = done_q;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nwords != '0) begin
                        state_d = READ;
                    end else begin
`ifdef SAMPLE_READER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            READ: begin
                busy = 1'b1;
                if (rd_en && (issue_q == last_idx)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (sample_xfer && last_sample) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SAMPLE_READER_CHECKSUM_EN
            CSUM: begin
                busy = 1'b1;
                if (m_ready) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
`ifndef SAMPLE_READER_CHECKSUM_EN
                // An empty readout has no final transfer, so done trails the DONE cycle.
                if (nwords_q == '0) begin
                    done_d = 1'b1;
                    busy   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            nwords_q    <= '0;
            issue_q     <= '0;
            xfer_q      <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= rd_en;
            if (accept) begin
                nwords_q <= nwords;
                issue_q  <= '0;
                xfer_q   <= '0;
`ifdef SAMPLE_READER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end
            if (rd_en) begin
                issue_q     <= issue_q + (ADDR_W+1)'(1);
                last_addr_q <= issue_q[ADDR_W-1:0];
            end
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (sample_xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
                xfer_q   <= xfer_q + (ADDR_W+1)'(1);
`ifdef SAMPLE_READER_CHECKSUM_EN
                csum_q   <= csum_q + fifo_q[rd_ptr_q];
`endif
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, sample_xfer};
        end
    end

endmodule

// File: tb/tb_sample_reader.sv
// Scoreboard bench for sample_reader; buffer word at address a is (a + 0x101) mod 2^10.
module tb_sample_reader;
    localparam int DW = 10;
    localparam int AW = 16;
`ifdef SAMPLE_READER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, rd_en, m_valid, m_ready, m_last, busy, done;
    logic [AW-1:0] nwords, rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_data;

    sample_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .nwords(nwords),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(int'(rd_addr) + 'h101);
        else       rd_data <= 10'h2AA;
    end

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] exp_addr[$];
    int n_checks = 0, n_fail = 0;
    int first_rd, first_v, done_cyc, n_rd, n_done, t0;
    int n_xfer = 0;
    logic [DW-1:0] last_word;
    bit            hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Monitor: compares every rd_en address and stream transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
                if (exp_addr.size() == 0) flag("extra rd_en");
                else check("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
            end
            if (m_valid) begin
                if (first_v < 0) first_v = cyc;
                if (hold_v) begin
                    check("m_data stable", 32'(m_data), 32'(hold_d));
                    check("m_last stable", 32'(m_last), 32'(hold_l));
                end
                if (m_ready) begin
                    hold_v = 1'b0;
                    n_xfer++;
                    last_word = m_data;
                    if (exp_q.size() == 0) flag("extra word");
                    else check("word {last,data}", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
                end else begin
                    hold_v = 1'b1;
                    hold_d = m_data;
                    hold_l = m_last;
                end
            end else if (hold_v) begin
                flag("m_valid dropped during stall");
                hold_v = 1'b0;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_obs();
        first_rd  = -1;
        first_v   = -1;
        done_cyc  = -1;
        n_rd      = 0;
        n_done    = 0;
        last_word = '1;
    endtask

    task automatic expect_run(input int n);
        logic [DW-1:0] s;
        logic [DW-1:0] d;
        s = '0;
        for (int i = 0; i < n; i++) begin
            d = DW'(i + 'h101);
            exp_addr.push_back(AW'(i));
            exp_q.push_back({(!CSUM_ON && (i == n - 1)), d});
            s = s + d;
        end
        if (CSUM_ON) exp_q.push_back({1'b1, s});
    endtask

    // Called at posedge+1; start is high for exactly the current cycle (T).
    task automatic do_start(input int n);
        start  = 1'b1;
        nwords = AW'(n);
        t0     = cyc;
        expect_run(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_until_done(input int mode, input int budget);
        int  d0;
        bit  got;
        d0  = n_done;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            m_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            if (n_done != d0) got = 1'b1;
        end
        if (!got) flag("done timeout");
        m_ready = 1'b1;
    endtask

    task automatic drain_check(input string tag);
        check({tag, " words left"}, 32'(exp_q.size()), 0);
        check({tag, " addrs left"}, 32'(exp_addr.size()), 0);
    endtask

    initial begin
        int base;
        bit hit;
        rst = 1'b1; start = 1'b0; nwords = '0; m_ready = 1'b1;
        clear_obs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset outputs", 32'({rd_en, m_valid, m_last, busy, done, rd_addr, m_data}), 0);

        // 3 words 0x101..0x103, started on the first cycle out of reset
        clear_obs();
        do_start(3);
        check("busy after start", 32'(busy), 1);
        run_until_done(0, 50);
        idle(3);
        check("3w first rd_en cycle", first_rd, t0 + 1);
        check("3w first m_valid cycle", first_v, t0 + 3);
        check("3w done cycle", done_cyc, CSUM_ON ? t0 + 7 : t0 + 6);
        check("3w final word", 32'(last_word), CSUM_ON ? 32'h306 : 32'h103);
        check("3w done pulses", n_done, 1);
        check("3w busy after done", 32'(busy), 0);
        drain_check("3w");

        // 8 words with m_ready pattern 1,0,0
        clear_obs();
        do_start(8);
        run_until_done(1, 200);
        idle(2);
        check("8w rd_en count", n_rd, 8);
        drain_check("8w");

        // empty readout
        clear_obs();
        base = n_xfer;
        do_start(0);
        run_until_done(0, 20);
        idle(2);
        check("0w rd_en count", n_rd, 0);
        check("0w first m_valid", first_v, CSUM_ON ? t0 + 1 : -1);
        check("0w transfers", n_xfer - base, CSUM_ON ? 1 : 0);
        check("0w checksum word", 32'(last_word), CSUM_ON ? 32'h0 : 32'h3FF);
        check("0w done cycle", done_cyc, t0 + 2);
        drain_check("0w");

        // reset during the 4th transfer of a 10-word readout
        clear_obs();
        base = n_xfer;
        do_start(10);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (n_xfer - base == 3) hit = 1'b1;
        end
        if (!hit) flag("reset point not reached");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-reset outputs", 32'({rd_en, m_valid, m_last, busy, done, rd_addr, m_data}), 0);
        exp_q.delete();
        exp_addr.delete();
        idle(12);
        check("mid-reset no done", n_done, 0);
        clear_obs();
        do_start(4);
        run_until_done(0, 50);
        idle(2);
        check("post-reset first rd_en", first_rd, t0 + 1);
        check("post-reset rd_en count", n_rd, 4);
        drain_check("post-reset");

        // start re-pulsed mid-readout must be ignored
        clear_obs();
        do_start(6);
        idle(2);
        start = 1'b1; nwords = AW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(0, 50);
        idle(4);
        check("repulse done pulses", n_done, 1);
        check("repulse rd_en count", n_rd, 6);
        drain_check("repulse");

        // full address range, no wrap
        clear_obs();
        do_start(65535);
        run_until_done(0, 70000);
        idle(2);
        check("full rd_en count", n_rd, 65535);
        drain_check("full");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
